// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the SPI register-bank master.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam int CMD_WIDTH = 8;
    localparam int RW_BIT    = 7;

    // Command byte: rw flag in the top bit, zero-extended address below it.
    function automatic logic [CMD_WIDTH-1:0] build_cmd(input logic rw, input logic [6:0] addr);
        logic [CMD_WIDTH-1:0] c;
        c         = {1'b0, addr};
        c[RW_BIT] = rw;
        return c;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Phase counter for the SPI master: one tick per CLK_DIV cycles of an active
// phase, decoded into rise/fall/sample strobes for spi_clk.
module spi_clk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic run_i,
    input  logic short_i,
    input  logic lead_i,
    input  logic shift_i,
    input  logic sclk_i,
    output logic tick_o,
    output logic rise_en_o,
    output logic fall_en_o,
    output logic sample_en_o
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    // A short phase ends one cycle early (used by the inter-frame gap).
    assign last   = (cnt_q == (short_i ? CW'(CLK_DIV - 2) : CW'(CLK_DIV - 1)));
    assign tick_o = ena && run_i && last;
    assign cnt_d  = (!run_i || last) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ena) begin
            cnt_q <= cnt_d;
        end
    end

    assign rise_en_o   = tick_o && (lead_i || (shift_i && !sclk_i));
    assign fall_en_o   = tick_o && shift_i && sclk_i;
    // MISO is taken on the last cycle of a high half, i.e. with the fall.
    assign sample_en_o = fall_en_o;

endmodule

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator: turns single-register read/write requests into
// {cmd byte, data} frames and captures MISO on reads.
module spi_reg_master
    import spi_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 8,
    parameter int CLK_DIV    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]  req_wdata,
    output logic                  rsp_valid,
    output logic [REG_WIDTH-1:0]  rsp_rdata,
    output logic                  busy,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);
    localparam int N  = CMD_WIDTH + REG_WIDTH;
    localparam int BW = $clog2(N);

    state_e               state_q;
    logic                 cs_n_q, sclk_q, mosi_q, rsp_valid_q, write_q;
    logic [N-1:0]         sh_q;
    logic [BW-1:0]        bit_q;
    logic [REG_WIDTH-1:0] rd_q, rdata_q;

    logic         miso_s;
    logic         tick, rise_en, fall_en, sample_en;
    logic [N-1:0] frame;

    sync2 u_miso_sync (
        .clk (clk),
        .rst (rst),
        .d_i (spi_miso),
        .q_o (miso_s)
    );

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .run_i       (state_q != IDLE),
        .short_i     (state_q == GAP),
        .lead_i      (state_q == SETUP),
        .shift_i     (state_q == SHIFT),
        .sclk_i      (sclk_q),
        .tick_o      (tick),
        .rise_en_o   (rise_en),
        .fall_en_o   (fall_en),
        .sample_en_o (sample_en)
    );

    assign frame = {build_cmd(req_write, 7'(req_addr)),
                    req_write ? req_wdata : {REG_WIDTH{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            write_q     <= 1'b0;
            sh_q        <= '0;
            bit_q       <= '0;
            rd_q        <= '0;
            rdata_q     <= '0;
        end else if (ena) begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q <= SETUP;
                        cs_n_q  <= 1'b0;
                        mosi_q  <= frame[N-1];
                        sh_q    <= {frame[N-2:0], 1'b0};
                        write_q <= req_write;
                        bit_q   <= '0;
                    end
                end
                SETUP: begin
                    if (rise_en) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise_en) sclk_q <= 1'b1;
                    if (fall_en) begin
                        sclk_q <= 1'b0;
                        if (sample_en && bit_q >= BW'(CMD_WIDTH))
                            rd_q <= {rd_q[REG_WIDTH-2:0], miso_s};
                        // No MOSI advance on the final fall; HOLD parks it low.
                        if (bit_q == BW'(N - 1)) begin
                            state_q <= HOLD;
                            mosi_q  <= 1'b0;
                        end else begin
                            mosi_q <= sh_q[N-1];
                            sh_q   <= {sh_q[N-2:0], 1'b0};
                            bit_q  <= bit_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_q     <= GAP;
                        cs_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (!write_q) rdata_q <= rd_q;
                    end
                end
                // GAP is one cycle short so a held req_valid re-accepts
                // exactly CLK_DIV cycles after CS rises.
                GAP: begin
                    if (tick) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = !req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with an SPI slave model on the bus.
module tb_spi_reg_master;
    localparam int D  = 8;
    localparam int N  = 16;
    localparam int D4 = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [2:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi;
    logic [7:0] rsp_rdata;
    logic       spi_miso = 1'b0;

    logic       ena4 = 1'b1, req_valid4 = 1'b0, req_write4 = 1'b0, spi_miso4 = 1'b0;
    logic [2:0] req_addr4 = '0;
    logic [7:0] req_wdata4 = '0;
    logic       req_ready4, rsp_valid4, busy4, spi_cs_n4, spi_clk4, spi_mosi4;
    logic [7:0] rsp_rdata4;

    spi_reg_master #(.ADDR_WIDTH(3), .REG_WIDTH(8), .CLK_DIV(D)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .spi_cs_n(spi_cs_n),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso));

    spi_reg_master #(.ADDR_WIDTH(3), .REG_WIDTH(8), .CLK_DIV(D4)) u_dut4 (
        .clk(clk), .rst(rst), .ena(ena4), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_write(req_write4), .req_addr(req_addr4), .req_wdata(req_wdata4),
        .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .busy(busy4), .spi_cs_n(spi_cs_n4),
        .spi_clk(spi_clk4), .spi_mosi(spi_mosi4), .spi_miso(spi_miso4));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and mode-0 slave: samples MOSI on spi_clk rise, shifts MISO after fall.
    logic [15:0] stx = '0;
    logic [15:0] srx = '0;
    logic [15:0] rxq[$];
    logic [7:0]  rsp_seen = '0;
    logic        p_cs = 1'b1, p_sclk = 1'b0, stall = 1'b0;
    int t_fall = 0, t_csr = 0, gap = 0, t_first = 0, t_lr = 0, t_lf = 0, t_rsp = 0;
    int n_rise = 0, rsp_cnt = 0, csf_cnt = 0, per_bad = 0, nb = 0, sb = 0;

    always @(negedge clk) begin
        if (p_cs && !spi_cs_n) begin
            t_fall   <= cyc;
            gap      <= cyc - t_csr;
            n_rise   <= 0;
            rsp_cnt  <= 0;
            csf_cnt  <= csf_cnt + 1;
            srx      <= '0;
            nb       <= 0;
            sb       <= 0;
            spi_miso <= stx[N-1];
        end
        if (!p_cs && spi_cs_n) begin
            t_csr <= cyc;
            if (nb == N) rxq.push_back(srx);
        end
        if (!spi_cs_n && !p_sclk && spi_clk) begin
            if (n_rise == 0) t_first <= cyc;
            else if (!stall && (cyc - t_lr) != 2 * D) per_bad <= per_bad + 1;
            t_lr   <= cyc;
            n_rise <= n_rise + 1;
            srx    <= {srx[N-2:0], spi_mosi};
            nb     <= nb + 1;
        end
        if (!spi_cs_n && p_sclk && !spi_clk) begin
            t_lf     <= cyc;
            sb       <= sb + 1;
            spi_miso <= (sb + 1 < N) ? stx[N-2-sb] : 1'b0;
        end
        if (rsp_valid) begin
            rsp_cnt  <= rsp_cnt + 1;
            t_rsp    <= cyc;
            rsp_seen <= rsp_rdata;
        end
        p_cs   <= spi_cs_n;
        p_sclk <= spi_clk;
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bool_wait: begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (req_ready && spi_cs_n) disable bool_wait;
            end
            chk({nm, "_timeout"}, 1, 0);
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  a;
        logic [7:0]  d;
        logic [7:0]  sd;
        logic [15:0] fr;
        logic [7:0]  rd;
    } vec_t;

    vec_t vt[5];

    initial begin
        int a0, base, frz_bad, lowc, nr, lr4, per4;
        logic [15:0] fr4;
        logic ssnap, msnap, csnap;

        vt[0] = '{1'b1, 3'd2, 8'hA5, 8'hFF, 16'h82A5, 8'h00};
        vt[1] = '{1'b0, 3'd6, 8'h00, 8'h3C, 16'h0600, 8'h3C};
        vt[2] = '{1'b1, 3'd7, 8'h5A, 8'h00, 16'h875A, 8'h3C};
        vt[3] = '{1'b0, 3'd0, 8'hFF, 8'hC3, 16'h0000, 8'hC3};
        vt[4] = '{1'b0, 3'd5, 8'h77, 8'h81, 16'h0500, 8'h81};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", int'(spi_cs_n), 1);
        chk("rst_sclk", int'(spi_clk), 0);
        chk("rst_mosi", int'(spi_mosi), 0);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);

        foreach (vt[i]) begin
            stx  = {8'h00, vt[i].sd};
            base = rxq.size();
            do_req(vt[i].w, vt[i].a, vt[i].d);
            chk($sformatf("v%0d_busy", i), int'(busy), 1);
            wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d_nframes", i), rxq.size() - base, 1);
            if (rxq.size() > 0) chk($sformatf("v%0d_frame", i), int'(rxq[$]), int'(vt[i].fr));
            chk($sformatf("v%0d_first_rise", i), t_first - t_fall, D);
            chk($sformatf("v%0d_last_fall", i), t_lf - t_fall, 2 * N * D);
            chk($sformatf("v%0d_cs_low", i), t_csr - t_fall, (2 * N + 1) * D);
            chk($sformatf("v%0d_rsp_time", i), t_rsp - t_fall, (2 * N + 1) * D);
            chk($sformatf("v%0d_rsp_cnt", i), rsp_cnt, 1);
            chk($sformatf("v%0d_rsp_rdata_at_pulse", i), int'(rsp_seen), int'(vt[i].rd));
            chk($sformatf("v%0d_rdata", i), int'(rsp_rdata), int'(vt[i].rd));
        end
        chk("sclk_period", per_bad, 0);

        // Back-to-back write then read with req_valid held high.
        stx  = 16'h0077;
        base = rxq.size();
        a0   = csf_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 8'h01;
        @(negedge clk);
        req_write = 1'b0; req_addr = 3'd0; req_wdata = 8'h00;
        bb_wait: begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (csf_cnt == a0 + 2) disable bb_wait;
            end
            chk("b2b_timeout", 1, 0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_cs_gap", gap, D);
        wait_idle("b2b");
        chk("b2b_nframes", rxq.size() - base, 2);
        if (rxq.size() >= 2) begin
            chk("b2b_frame0", int'(rxq[$-1]), 16'h8101);
            chk("b2b_frame1", int'(rxq[$]), 16'h0000);
        end
        chk("b2b_rdata", int'(rsp_rdata), 8'h77);
        chk("b2b_csf_total", csf_cnt - a0, 2);

        // ena low for 50 cycles starting at edge 100 of a write.
        stall = 1'b1;
        base  = rxq.size();
        frz_bad = 0;
        do_req(1'b1, 3'd3, 8'h96);
        a0 = cyc;
        for (int i = 0; i < 200 && cyc < a0 + 99; i++) @(negedge clk);
        ena = 1'b0;
        ssnap = spi_clk; msnap = spi_mosi; csnap = spi_cs_n;
        repeat (50) begin
            @(negedge clk);
            if (spi_clk !== ssnap || spi_mosi !== msnap || spi_cs_n !== csnap) frz_bad++;
        end
        ena = 1'b1;
        wait_idle("ena");
        stall = 1'b0;
        chk("ena_frozen", frz_bad, 0);
        chk("ena_nframes", rxq.size() - base, 1);
        if (rxq.size() > 0) chk("ena_frame", int'(rxq[$]), 16'h8396);
        chk("ena_first_rise", t_first - t_fall, D);
        chk("ena_last_fall", t_lf - t_fall, 2 * N * D + 50);
        chk("ena_cs_low", t_csr - t_fall, (2 * N + 1) * D + 50);
        chk("ena_rsp_time", t_rsp - t_fall, (2 * N + 1) * D + 50);
        chk("ena_rdata", int'(rsp_rdata), 8'h77);

        // Reset pulse at edge 130 of a write.
        base = rxq.size();
        do_req(1'b1, 3'd4, 8'h11);
        a0 = cyc;
        for (int i = 0; i < 200 && cyc < a0 + 129; i++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_cs_n", int'(spi_cs_n), 1);
        chk("rstmid_sclk", int'(spi_clk), 0);
        chk("rstmid_ready", int'(req_ready), 1);
        chk("rstmid_rsp_valid", int'(rsp_valid), 0);
        #1 rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("rstmid_no_rsp", rsp_cnt, 0);
        chk("rstmid_no_frame", rxq.size() - base, 0);
        chk("rstmid_rdata", int'(rsp_rdata), 0);
        stx = 16'h005E;
        do_req(1'b0, 3'd1, 8'h00);
        wait_idle("after_rst");
        chk("after_rst_nframes", rxq.size() - base, 1);
        if (rxq.size() > 0) chk("after_rst_frame", int'(rxq[$]), 16'h0100);
        chk("after_rst_rdata", int'(rsp_rdata), 8'h5E);

        // req_valid toggled while busy: exactly one frame.
        a0   = csf_cnt;
        base = rxq.size();
        do_req(1'b1, 3'd6, 8'hC7);
        tg: begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (req_ready) begin
                    req_valid = 1'b0;
                    disable tg;
                end
                req_valid = ~req_valid;
            end
            chk("toggle_timeout", 1, 0);
        end
        req_valid = 1'b0;
        repeat (300) @(negedge clk);
        chk("toggle_csf", csf_cnt - a0, 1);
        chk("toggle_nframes", rxq.size() - base, 1);
        if (rxq.size() > 0) chk("toggle_frame", int'(rxq[$]), 16'h86C7);
        chk("toggle_period", per_bad, 0);

        // CLK_DIV=4 instance: write addr 5, data 0x3E.
        @(negedge clk);
        req_valid4 = 1'b1; req_write4 = 1'b1; req_addr4 = 3'd5; req_wdata4 = 8'h3E;
        @(negedge clk);
        req_valid4 = 1'b0;
        lowc = 0; nr = 0; lr4 = 0; per4 = 0; fr4 = '0; ssnap = 1'b0;
        for (int e = 0; e < 400; e++) begin
            if (spi_cs_n4) break;
            lowc++;
            if (spi_clk4 && !ssnap) begin
                if (nr == 0) chk("d4_first_rise", e, D4);
                else if (e - lr4 != 2 * D4) per4++;
                lr4 = e;
                nr++;
                fr4 = {fr4[14:0], spi_mosi4};
            end
            ssnap = spi_clk4;
            @(negedge clk);
        end
        chk("d4_cs_low", lowc, (2 * N + 1) * D4);
        chk("d4_rises", nr, N);
        chk("d4_period", per4, 0);
        chk("d4_frame", int'(fr4), 16'h853E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
